axis_pkt_fifo: RTL and testbench



---
 rtl/axis_pkg.sv | 16 +
 rtl/axis_pkt_fifo_if.sv | 16 +
 rtl/axis_fifo_ram.sv | 33 +++
 rtl/axis_pkt_fifo.sv | 159 +++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO: write-side state and
// pointer sizing.
package axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_e;

    // One extra MSB above the address bits separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream bundle; master drives the payload, slave drives tready.
interface axis_pkt_fifo_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port RAM, single clock, registered read port that holds its
// last value while rd_en is low.
module axis_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Read register only reloads when a read is issued.
    always_comb begin
        rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
    end

    // Storage array and read register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream FIFO with optional store-and-forward frame mode,
// overflow and bad-frame dropping, and registered status outputs.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH     = 1,
    parameter int DEPTH          = 32,
    parameter int FRAME_FIFO     = 1,
    parameter int DROP_WHEN_FULL = 1,
    parameter int DROP_BAD_FRAME = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_pkt_fifo_if.slave        s_axis,
    axis_pkt_fifo_if.master       m_axis,
    output logic [$clog2(DEPTH):0] status_depth,
    output logic                  status_overflow,
    output logic                  status_bad_frame,
    output logic                  status_good_frame
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam int RW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam bit FRAME_MODE = (FRAME_FIFO != 0);
    localparam bit DROP_FULL  = FRAME_MODE && (DROP_WHEN_FULL != 0);
    localparam bit DROP_BAD   = FRAME_MODE && (DROP_BAD_FRAME != 0);

    logic [PW-1:0] wr_ptr_cur_q, wr_ptr_cur_d;
    logic [PW-1:0] wr_ptr_commit_q, wr_ptr_commit_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] depth_q, depth_d;
    wr_state_e     state_q, state_d;
    logic          rdy_en_q, rdy_en_d;
    logic          ram_vld_q, ram_vld_d;
    logic          out_vld_q, out_vld_d;
    logic [RW-1:0] out_word_q, out_word_d;
    logic          ovf_q, ovf_d, bad_q, bad_d, good_q, good_d;

    logic          full_cur_s, empty_s, s_ready_s, accept_s;
    logic          wr_en_s, rd_en_s, load_out_s;
    logic [RW-1:0] wr_word_s, ram_rdata_s;

    assign full_cur_s = (wr_ptr_cur_q - rd_ptr_q) == DEPTH_PTR;
    assign empty_s    = (rd_ptr_q == wr_ptr_commit_q);
    assign s_ready_s  = rdy_en_q & (DROP_FULL | ~full_cur_s);
    assign accept_s   = s_axis.tvalid & s_ready_s;
    assign wr_word_s  = {s_axis.tlast, s_axis.tuser, s_axis.tkeep, s_axis.tdata};

    // Write side: pointer advance, commit, frame drop and status pulses.
    always_comb begin
        wr_ptr_cur_d    = wr_ptr_cur_q;
        wr_ptr_commit_d = wr_ptr_commit_q;
        state_d         = state_q;
        wr_en_s         = 1'b0;
        ovf_d           = 1'b0;
        bad_d           = 1'b0;
        good_d          = 1'b0;
        if (accept_s) begin
            if (!FRAME_MODE) begin
                wr_en_s         = 1'b1;
                wr_ptr_cur_d    = wr_ptr_cur_q + PTR_ONE;
                wr_ptr_commit_d = wr_ptr_cur_q + PTR_ONE;
                good_d          = s_axis.tlast;
            end else if ((state_q == ST_DROP) || full_cur_s) begin
                // Overflow: discard the partial frame and swallow the rest of it.
                wr_ptr_cur_d = wr_ptr_commit_q;
                state_d      = s_axis.tlast ? ST_IDLE : ST_DROP;
                ovf_d        = s_axis.tlast;
            end else if (s_axis.tlast && DROP_BAD && s_axis.tuser[0]) begin
                wr_ptr_cur_d = wr_ptr_commit_q;
                state_d      = ST_IDLE;
                bad_d        = 1'b1;
            end else if (s_axis.tlast) begin
                wr_en_s         = 1'b1;
                wr_ptr_cur_d    = wr_ptr_cur_q + PTR_ONE;
                wr_ptr_commit_d = wr_ptr_cur_q + PTR_ONE;
                state_d         = ST_IDLE;
                good_d          = 1'b1;
            end else begin
                wr_en_s      = 1'b1;
                wr_ptr_cur_d = wr_ptr_cur_q + PTR_ONE;
                state_d      = ST_FRAME;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Read side: RAM read register acts as a prefetch stage ahead of the output register.
    always_comb begin
        load_out_s = ram_vld_q & (~out_vld_q | m_axis.tready);
        rd_en_s    = ~empty_s & (~ram_vld_q | load_out_s);
        rd_ptr_d   = rd_en_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        ram_vld_d  = rd_en_s ? 1'b1 : (load_out_s ? 1'b0 : ram_vld_q);
        out_vld_d  = load_out_s ? 1'b1 : (m_axis.tready ? 1'b0 : out_vld_q);
        out_word_d = load_out_s ? ram_rdata_s : out_word_q;
        depth_d    = wr_ptr_commit_q - rd_ptr_q;
        rdy_en_d   = 1'b1;
    end

    // State registers; reset flushes both sides of the FIFO.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_cur_q    <= '0;
            wr_ptr_commit_q <= '0;
            rd_ptr_q        <= '0;
            depth_q         <= '0;
            state_q         <= ST_IDLE;
            rdy_en_q        <= 1'b0;
            ram_vld_q       <= 1'b0;
            out_vld_q       <= 1'b0;
            out_word_q      <= '0;
            ovf_q           <= 1'b0;
            bad_q           <= 1'b0;
            good_q          <= 1'b0;
        end else begin
            wr_ptr_cur_q    <= wr_ptr_cur_d;
            wr_ptr_commit_q <= wr_ptr_commit_d;
            rd_ptr_q        <= rd_ptr_d;
            depth_q         <= depth_d;
            state_q         <= state_d;
            rdy_en_q        <= rdy_en_d;
            ram_vld_q       <= ram_vld_d;
            out_vld_q       <= out_vld_d;
            out_word_q      <= out_word_d;
            ovf_q           <= ovf_d;
            bad_q           <= bad_d;
            good_q          <= good_d;
        end
    end

    axis_fifo_ram #(
        .WIDTH (RW),
        .AW    (AW)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_cur_q[AW-1:0]),
        .wr_data (wr_word_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (ram_rdata_s)
    );

    assign s_axis.tready     = s_ready_s;
    assign m_axis.tvalid     = out_vld_q;
    assign m_axis.tdata      = out_word_q[DATA_WIDTH-1:0];
    assign m_axis.tkeep      = out_word_q[DATA_WIDTH+KEEP_WIDTH-1:DATA_WIDTH];
    assign m_axis.tuser      = out_word_q[RW-2:DATA_WIDTH+KEEP_WIDTH];
    assign m_axis.tlast      = out_word_q[RW-1];
    assign status_depth      = depth_q;
    assign status_overflow   = ovf_q;
    assign status_bad_frame  = bad_q;
    assign status_good_frame = good_q;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench: three FIFO configurations (streaming DEPTH=4, frame mode
// with drops DEPTH=8, frame mode without overflow drop DEPTH=8).
module tb_axis_pkt_fifo;
    localparam int DW = 16;
    localparam int KW = 2;
    localparam int UW = 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 aclk = ~aclk;

    axis_pkt_fifo_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) a_s (), a_m (), b_s (), b_m (), c_s (), c_m ();

    logic [2:0] a_depth;
    logic [3:0] b_depth, c_depth;
    logic a_ovf, a_bad, a_good, b_ovf, b_bad, b_good, c_ovf, c_bad, c_good;

    axis_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEPTH(4),
                    .FRAME_FIFO(0), .DROP_WHEN_FULL(1), .DROP_BAD_FRAME(1)) u_a (
        .aclk(aclk), .aresetn(aresetn), .s_axis(a_s), .m_axis(a_m), .status_depth(a_depth),
        .status_overflow(a_ovf), .status_bad_frame(a_bad), .status_good_frame(a_good));

    axis_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEPTH(8),
                    .FRAME_FIFO(1), .DROP_WHEN_FULL(1), .DROP_BAD_FRAME(1)) u_b (
        .aclk(aclk), .aresetn(aresetn), .s_axis(b_s), .m_axis(b_m), .status_depth(b_depth),
        .status_overflow(b_ovf), .status_bad_frame(b_bad), .status_good_frame(b_good));

    axis_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEPTH(8),
                    .FRAME_FIFO(1), .DROP_WHEN_FULL(0), .DROP_BAD_FRAME(1)) u_c (
        .aclk(aclk), .aresetn(aresetn), .s_axis(c_s), .m_axis(c_m), .status_depth(c_depth),
        .status_overflow(c_ovf), .status_bad_frame(c_bad), .status_good_frame(c_good));

    beat_t b_out[$];
    beat_t c_out[$];
    int b_ovf_n, b_bad_n, b_good_n, b_depth_max, c_bad_n, c_good_n;

    // Output monitors and status pulse counters, sampled mid-cycle.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (b_m.tvalid && b_m.tready) b_out.push_back({b_m.tdata, b_m.tkeep, b_m.tuser, b_m.tlast});
            if (c_m.tvalid && c_m.tready) c_out.push_back({c_m.tdata, c_m.tkeep, c_m.tuser, c_m.tlast});
            if (b_ovf)  b_ovf_n++;
            if (b_bad)  b_bad_n++;
            if (b_good) b_good_n++;
            if (c_bad)  c_bad_n++;
            if (c_good) c_good_n++;
            if (int'(b_depth) > b_depth_max) b_depth_max = int'(b_depth);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_b();
        b_out.delete();
        b_ovf_n = 0; b_bad_n = 0; b_good_n = 0; b_depth_max = 0;
    endtask

    task automatic b_beat(input logic [DW-1:0] d, input logic l, input logic u);
        b_s.tdata = d; b_s.tkeep = 2'b11; b_s.tlast = l; b_s.tuser = u; b_s.tvalid = 1'b1;
        step();
        b_s.tvalid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (a_s.tready !== 1'b0 || b_s.tready !== 1'b0 || c_s.tready !== 1'b0) begin
            errors++; $display("FAIL rst_tready_low: got %b%b%b expected 000", a_s.tready, b_s.tready, c_s.tready); end
        checks++; if (a_m.tvalid !== 1'b0 || b_m.tvalid !== 1'b0 || c_m.tvalid !== 1'b0) begin
            errors++; $display("FAIL rst_tvalid: got %b%b%b expected 000", a_m.tvalid, b_m.tvalid, c_m.tvalid); end
        checks++; if ({b_depth, b_ovf, b_bad, b_good} !== 7'd0) begin
            errors++; $display("FAIL rst_status: got %h expected 0", {b_depth, b_ovf, b_bad, b_good}); end
        aresetn = 1'b1;
        #1;
        checks++; if (b_s.tready !== 1'b0 || a_s.tready !== 1'b0) begin
            errors++; $display("FAIL rst_first_cycle: got %b%b expected 00", a_s.tready, b_s.tready); end
        step();
        checks++; if (a_s.tready !== 1'b1 || b_s.tready !== 1'b1 || c_s.tready !== 1'b1) begin
            errors++; $display("FAIL rst_tready_up: got %b%b%b expected 111", a_s.tready, b_s.tready, c_s.tready); end
    endtask

    task automatic test_nonframe();
        beat_t exp_q[$];
        beat_t got, want;
        int accepted = 0;
        a_m.tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_s.tdata = 16'($urandom); a_s.tkeep = 2'b11; a_s.tuser = 1'b0;
            a_s.tlast = (i % 3 == 2); a_s.tvalid = 1'b1;
            if (a_s.tready === 1'b1) begin
                exp_q.push_back({a_s.tdata, a_s.tkeep, a_s.tuser, a_s.tlast});
                accepted++;
            end
            step();
            if (i == 1) begin checks++; if (a_m.tvalid !== 1'b0) begin
                errors++; $display("FAIL nf_latency_early: got %b expected 0", a_m.tvalid); end end
            if (i == 2) begin checks++; if (a_m.tvalid !== 1'b1) begin
                errors++; $display("FAIL nf_latency: got %b expected 1", a_m.tvalid); end end
        end
        a_s.tvalid = 1'b0;
        // DEPTH words in RAM plus one in the read register and one in the output register.
        checks++; if (accepted != 6) begin
            errors++; $display("FAIL nf_capacity: got %0d expected 6", accepted); end
        checks++; if (a_s.tready !== 1'b0) begin
            errors++; $display("FAIL nf_full_tready: got %b expected 0", a_s.tready); end
        checks++; if (a_depth !== 3'd4) begin
            errors++; $display("FAIL nf_depth: got %0d expected 4", a_depth); end
        a_m.tready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (a_m.tvalid === 1'b1) begin
                got = {a_m.tdata, a_m.tkeep, a_m.tuser, a_m.tlast};
                want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++; if (got !== want) begin
                    errors++; $display("FAIL nf_data: got %h expected %h", got, want); end
            end
            step();
        end
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL nf_lost: got %0d beats left expected 0", exp_q.size()); end
    endtask

    task automatic test_frame();
        beat_t d [3];
        clear_b();
        b_m.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d[i] = {16'($urandom), 2'($urandom), 1'b0, (i == 2)};
            b_s.tdata = d[i].d; b_s.tkeep = d[i].k; b_s.tuser = d[i].u; b_s.tlast = d[i].l; b_s.tvalid = 1'b1;
            step();
            checks++; if (b_m.tvalid !== 1'b0) begin
                errors++; $display("FAIL fr_early_valid: beat %0d got %b expected 0", i, b_m.tvalid); end
        end
        b_s.tvalid = 1'b0;
        checks++; if (b_good !== 1'b1) begin
            errors++; $display("FAIL fr_good_pulse: got %b expected 1", b_good); end
        step();
        checks++; if (b_m.tvalid !== 1'b0) begin
            errors++; $display("FAIL fr_latency_early: got %b expected 0", b_m.tvalid); end
        step();
        for (int j = 0; j < 3; j++) begin
            checks++; if (b_m.tvalid !== 1'b1 || {b_m.tdata, b_m.tkeep, b_m.tuser, b_m.tlast} !== d[j]) begin
                errors++; $display("FAIL fr_beat: %0d got v=%b %h expected v=1 %h", j, b_m.tvalid,
                                   {b_m.tdata, b_m.tkeep, b_m.tuser, b_m.tlast}, d[j]); end
            step();
        end
        checks++; if (b_m.tvalid !== 1'b0 || b_good_n != 1) begin
            errors++; $display("FAIL fr_after: got v=%b good=%0d expected v=0 good=1", b_m.tvalid, b_good_n); end
    endtask

    task automatic test_bad_frame();
        logic [DW-1:0] g0, g1;
        g0 = 16'($urandom); g1 = 16'($urandom);
        clear_b();
        b_m.tready = 1'b1;
        b_beat(16'h0BAD, 1'b0, 1'b0);
        b_beat(16'h1BAD, 1'b1, 1'b1);
        b_beat(g0, 1'b0, 1'b0);
        b_beat(g1, 1'b1, 1'b0);
        repeat (8) step();
        checks++; if (b_out.size() != 2) begin
            errors++; $display("FAIL bad_count: got %0d beats expected 2", b_out.size()); end
        else begin
            checks++; if (b_out[0] !== {g0, 2'b11, 1'b0, 1'b0} || b_out[1] !== {g1, 2'b11, 1'b0, 1'b1}) begin
                errors++; $display("FAIL bad_data: got %h %h expected %h %h", b_out[0], b_out[1],
                                   {g0, 2'b11, 1'b0, 1'b0}, {g1, 2'b11, 1'b0, 1'b1}); end
        end
        checks++; if (b_bad_n != 1 || b_good_n != 1) begin
            errors++; $display("FAIL bad_pulses: got bad=%0d good=%0d expected 1 1", b_bad_n, b_good_n); end
        checks++; if (b_depth_max > 2) begin
            errors++; $display("FAIL bad_depth: got %0d expected <=2", b_depth_max); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] g [3];
        logic ready_ok = 1'b1;
        clear_b();
        b_m.tready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (b_s.tready !== 1'b1) ready_ok = 1'b0;
            b_beat(16'($urandom), (i == 39), 1'b0);
        end
        checks++; if (b_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_pulse_at_tlast: got %b expected 1", b_ovf); end
        for (int i = 0; i < 3; i++) begin
            g[i] = 16'($urandom);
            if (b_s.tready !== 1'b1) ready_ok = 1'b0;
            b_beat(g[i], (i == 2), 1'b0);
        end
        checks++; if (!ready_ok) begin
            errors++; $display("FAIL ovf_tready: got dropped expected always 1"); end
        repeat (2) step();
        b_m.tready = 1'b1;
        repeat (10) step();
        checks++; if (b_out.size() != 3) begin
            errors++; $display("FAIL ovf_count: got %0d beats expected 3", b_out.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (b_out[i] !== {g[i], 2'b11, 1'b0, (i == 2)}) begin
                    errors++; $display("FAIL ovf_data: %0d got %h expected %h", i, b_out[i], {g[i], 2'b11, 1'b0, (i == 2)}); end
            end
        end
        checks++; if (b_ovf_n != 1 || b_good_n != 1) begin
            errors++; $display("FAIL ovf_pulses: got ovf=%0d good=%0d expected 1 1", b_ovf_n, b_good_n); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] n [3];
        clear_b();
        b_m.tready = 1'b0;
        b_beat(16'h1111, 1'b0, 1'b0);
        b_beat(16'h2222, 1'b1, 1'b0);
        repeat (3) step();
        checks++; if (b_m.tvalid !== 1'b1) begin
            errors++; $display("FAIL mid_precond: got %b expected 1", b_m.tvalid); end
        b_beat(16'h3333, 1'b0, 1'b0);
        b_beat(16'h4444, 1'b0, 1'b0);
        b_s.tdata = 16'h5555; b_s.tlast = 1'b0; b_s.tvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        checks++; if (b_m.tvalid !== 1'b0 || b_depth !== 4'd0 || b_s.tready !== 1'b0) begin
            errors++; $display("FAIL mid_flush: got v=%b depth=%0d rdy=%b expected 0 0 0", b_m.tvalid, b_depth, b_s.tready); end
        b_s.tvalid = 1'b0;
        step(); step();
        aresetn = 1'b1;
        step();
        clear_b();
        b_m.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n[i] = 16'($urandom);
            b_beat(n[i], (i == 2), 1'b0);
        end
        repeat (8) step();
        checks++; if (b_out.size() != 3) begin
            errors++; $display("FAIL mid_count: got %0d beats expected 3", b_out.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (b_out[i] !== {n[i], 2'b11, 1'b0, (i == 2)}) begin
                    errors++; $display("FAIL mid_data: %0d got %h expected %h", i, b_out[i], {n[i], 2'b11, 1'b0, (i == 2)}); end
            end
        end
    endtask

    task automatic test_random();
        beat_t exp_q[$];
        beat_t frm[$];
        beat_t bt, got;
        int good_exp = 0, bad_exp = 0, guard, shown = 0;
        logic bad, timed_out = 1'b0;
        c_out.delete(); c_bad_n = 0; c_good_n = 0;
        for (int f = 0; f < 3000 && !timed_out; f++) begin
            int len = $urandom_range(1, 8);
            bad = ($urandom_range(0, 4) == 0);
            frm.delete();
            for (int b = 0; b < len && !timed_out; b++) begin
                bt = {16'($urandom), 2'($urandom), (b == len - 1) ? bad : 1'($urandom), (b == len - 1)};
                frm.push_back(bt);
                while ($urandom_range(0, 1) == 1) begin
                    c_s.tvalid = 1'b0; c_m.tready = 1'($urandom); step();
                end
                c_s.tdata = bt.d; c_s.tkeep = bt.k; c_s.tuser = bt.u; c_s.tlast = bt.l; c_s.tvalid = 1'b1;
                guard = 0;
                forever begin
                    c_m.tready = 1'($urandom);
                    if (c_s.tready === 1'b1) break;
                    step();
                    guard++;
                    if (guard > 1000) begin timed_out = 1'b1; break; end
                end
                step();
                c_s.tvalid = 1'b0;
            end
            if (bad) bad_exp++;
            else begin good_exp++; foreach (frm[i]) exp_q.push_back(frm[i]); end
        end
        checks++; if (timed_out) begin
            errors++; $display("FAIL rnd_timeout: got stalled tready expected progress"); end
        c_m.tready = 1'b1;
        guard = 0;
        while (c_out.size() < exp_q.size() && guard < 500) begin step(); guard++; end
        repeat (4) step();
        checks++; if (c_out.size() != exp_q.size()) begin
            errors++; $display("FAIL rnd_count: got %0d beats expected %0d", c_out.size(), exp_q.size()); end
        while (exp_q.size() > 0 && c_out.size() > 0) begin
            bt = exp_q.pop_front(); got = c_out.pop_front();
            checks++; if (got !== bt) begin
                errors++;
                if (shown < 10) begin shown++; $display("FAIL rnd_beat: got %h expected %h", got, bt); end
            end
        end
        checks++; if (c_good_n != good_exp || c_bad_n != bad_exp) begin
            errors++; $display("FAIL rnd_pulses: got good=%0d bad=%0d expected %0d %0d", c_good_n, c_bad_n, good_exp, bad_exp); end
    endtask

    initial begin
        a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tkeep = '0; a_s.tlast = 1'b0; a_s.tuser = '0; a_m.tready = 1'b0;
        b_s.tvalid = 1'b0; b_s.tdata = '0; b_s.tkeep = '0; b_s.tlast = 1'b0; b_s.tuser = '0; b_m.tready = 1'b0;
        c_s.tvalid = 1'b0; c_s.tdata = '0; c_s.tkeep = '0; c_s.tlast = 1'b0; c_s.tuser = '0; c_m.tready = 1'b0;
        test_reset();
        test_nonframe();
        test_frame();
        test_bad_frame();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
